// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Requests are
// arbitrated round-robin in IDLE. The winner's operands and operate code are
// registered onto the ALU inputs. The ALU result is captured one cycle later
// and returned with a one-cycle done pulse to the granted requester.
// One operation takes three cycles: IDLE -> EXEC -> RESP -> IDLE.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   req0/a0/b0/op0        requester 0: request, operand in0, operand in1, op
//   req1/a1/b1/op1        requester 1: same meaning as requester 0
//   done0, done1          one-cycle pulse; res holds that requester's result
//   res                   registered ALU result, valid while a done is high
//   busy                  high while in EXEC and RESP
//   alu_in0/alu_in1       registered operands driving the ALU
//   alu_op                registered operate code driving the ALU
//   alu_out               combinational ALU result
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;               // requester currently served
    logic             last_grant_q, last_grant_d; // last requester served
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] alu_in0_q, alu_in0_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             win;

    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that skips an assignment would otherwise infer a latch.
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        busy_d       = 1'b0;
        res_d        = res_q;
        alu_in0_d    = alu_in0_q;
        alu_in1_d    = alu_in1_q;
        alu_op_d     = alu_op_q;
        win          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // A tie goes to whoever was not served last.
                    // A single request goes to its own requester.
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    gnt_d        = win;
                    last_grant_d = win;
                    alu_in0_d    = win ? a1  : a0;
                    alu_in1_d    = win ? b1  : b0;
                    alu_op_d     = win ? op1 : op0;
                    busy_d       = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // The ALU settled from the registered inputs during this cycle.
                res_d   = alu_out;
                done0_d = ~gnt_q;
                done1_d = gnt_q;
                busy_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample their _d values from before the edge, with no ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1; // requester 0 wins the first tie
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
            res_q        <= '0;
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
            alu_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
            res_q        <= res_d;
            alu_in0_q    <= alu_in0_d;
            alu_in1_q    <= alu_in1_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
    assign res     = res_q;
    assign alu_in0 = alu_in0_q;
    assign alu_in1 = alu_in1_q;
    assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. The ALU is modelled as an adder. The
// testbench drives inputs and samples outputs on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [OPW-1:0]   op0, op1;
    logic             done0, done1, busy;
    logic [WIDTH-1:0] res, alu_in0, alu_in1, alu_out;
    logic [OPW-1:0]   alu_op;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // ALU model: the operate code is only observed at the port.
    assign alu_out = alu_in0 + alu_in1;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .op0     (op0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .op1     (op1),
        .done0   (done0),
        .done1   (done1),
        .res     (res),
        .busy    (busy),
        .alu_in0 (alu_in0),
        .alu_in1 (alu_in1),
        .alu_op  (alu_op),
        .alu_out (alu_out)
    );

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0;
        a1 = '0; b1 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_done0: got %b expected 0", done0); end
        tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL reset_done1: got %b expected 0", done1); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (res !== 16'h0000) begin tests_failed++; $display("FAIL reset_res: got %h expected 0000", res); end
        tests_run++; if (alu_in0 !== 16'h0000 || alu_in1 !== 16'h0000) begin tests_failed++; $display("FAIL reset_alu_in: got %h/%h expected 0000/0000", alu_in0, alu_in1); end
        tests_run++; if (alu_op !== 3'b000) begin tests_failed++; $display("FAIL reset_alu_op: got %b expected 000", alu_op); end
    endtask

    task automatic test_single();
        @(negedge clk);
        a0 = 16'h000f; b0 = 16'h0002; op0 = 3'b011; req0 = 1'b1;
        @(negedge clk); // after E0: EXEC
        tests_run++; if (alu_op !== 3'b011) begin tests_failed++; $display("FAIL single_alu_op: got %b expected 011", alu_op); end
        tests_run++; if (alu_in0 !== 16'h000f || alu_in1 !== 16'h0002) begin tests_failed++; $display("FAIL single_alu_in: got %h/%h expected 000f/0002", alu_in0, alu_in1); end
        tests_run++; if (busy !== 1'b1 || done0 !== 1'b0) begin tests_failed++; $display("FAIL single_exec: got busy=%b done0=%b expected busy=1 done0=0", busy, done0); end
        @(negedge clk); // after E1: RESP
        tests_run++; if (done0 !== 1'b1 || done1 !== 1'b0) begin tests_failed++; $display("FAIL single_done: got done0=%b done1=%b expected 1/0", done0, done1); end
        tests_run++; if (res !== 16'h0011) begin tests_failed++; $display("FAIL single_res: got %h expected 0011", res); end
        req0 = 1'b0;
        @(negedge clk); // back in IDLE
        tests_run++; if (done0 !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_end: got done0=%b busy=%b expected 0/0", done0, busy); end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 16'h000f; b0 = 16'h0002; op0 = 3'b011;
        a1 = 16'h0100; b1 = 16'h0001; op1 = 3'b101;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic       exp_side;
            logic       seen;
            int         waited;
            logic [WIDTH-1:0] exp_res;
            exp_side = k[0];
            exp_res  = exp_side ? 16'h0101 : 16'h0011;
            seen     = 1'b0;
            waited   = 0;
            while (!seen && waited < 8) begin
                @(negedge clk);
                waited++;
                if (done0 || done1) seen = 1'b1;
            end
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL rr_timeout_%0d: got no done within 8 cycles expected done", k);
            end else if ({done0, done1} !== {~exp_side, exp_side} || res !== exp_res) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got done0=%b done1=%b res=%h expected done0=%b done1=%b res=%h",
                         k, done0, done1, res, ~exp_side, exp_side, exp_res);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_late_req1();
        @(negedge clk);
        a0 = 16'h000f; b0 = 16'h0002; op0 = 3'b011; req0 = 1'b1;
        @(negedge clk); // requester 0 in EXEC
        a1 = 16'h0100; b1 = 16'h0001; op1 = 3'b101; req1 = 1'b1;
        tests_run++; if (busy !== 1'b1 || done0 !== 1'b0) begin tests_failed++; $display("FAIL late_exec: got busy=%b done0=%b expected 1/0", busy, done0); end
        @(negedge clk); // RESP for requester 0
        tests_run++; if (done0 !== 1'b1 || done1 !== 1'b0 || res !== 16'h0011) begin tests_failed++; $display("FAIL late_done0: got done0=%b done1=%b res=%h expected 1/0/0011", done0, done1, res); end
        req0 = 1'b0;
        @(negedge clk); // IDLE: req1 not yet granted
        tests_run++; if (done1 !== 1'b0 || busy !== 1'b0 || res !== 16'h0011) begin tests_failed++; $display("FAIL late_idle: got done1=%b busy=%b res=%h expected 0/0/0011", done1, busy, res); end
        @(negedge clk); // requester 1 in EXEC
        tests_run++; if (busy !== 1'b1 || alu_in0 !== 16'h0100 || alu_op !== 3'b101 || done1 !== 1'b0) begin tests_failed++; $display("FAIL late_exec1: got busy=%b in0=%h op=%b done1=%b expected 1/0100/101/0", busy, alu_in0, alu_op, done1); end
        @(negedge clk); // RESP for requester 1: 3 cycles after done0
        tests_run++; if (done1 !== 1'b1 || done0 !== 1'b0 || res !== 16'h0101) begin tests_failed++; $display("FAIL late_done1: got done1=%b done0=%b res=%h expected 1/0/0101", done1, done0, res); end
        req1 = 1'b0;
        @(negedge clk);
        tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL late_done1_pulse: got %b expected 0", done1); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a1 = 16'h0100; b1 = 16'h0001; op1 = 3'b101; req1 = 1'b1;
        @(negedge clk); // requester 1 in EXEC
        tests_run++; if (busy !== 1'b1 || alu_in0 !== 16'h0100) begin tests_failed++; $display("FAIL rstmid_exec: got busy=%b in0=%h expected 1/0100", busy, alu_in0); end
        #1 rst = 1'b1;
        #1;
        tests_run++; if (done1 !== 1'b0 || busy !== 1'b0 || res !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_async: got done1=%b busy=%b res=%h expected 0/0/0000", done1, busy, res); end
        tests_run++; if (alu_in0 !== 16'h0000 || alu_in1 !== 16'h0000 || alu_op !== 3'b000) begin tests_failed++; $display("FAIL rstmid_alu: got %h/%h/%b expected 0000/0000/000", alu_in0, alu_in1, alu_op); end
        a0 = 16'h000f; b0 = 16'h0002; op0 = 3'b011; req0 = 1'b1;
        @(negedge clk); // a clock edge passed while reset was held
        tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done1: got %b expected 0", done1); end
        rst = 1'b0;
        @(negedge clk); // both requests high: requester 0 wins after reset
        tests_run++; if (busy !== 1'b1 || alu_in0 !== 16'h000f || alu_op !== 3'b011) begin tests_failed++; $display("FAIL rstmid_first_grant: got busy=%b in0=%h op=%b expected 1/000f/011", busy, alu_in0, alu_op); end
        @(negedge clk);
        tests_run++; if (done0 !== 1'b1 || done1 !== 1'b0 || res !== 16'h0011) begin tests_failed++; $display("FAIL rstmid_done0: got done0=%b done1=%b res=%h expected 1/0/0011", done0, done1, res); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int               busy_cnt;
        int               done_cnt;
        logic [WIDTH-1:0] got_res;
        busy_cnt = 0;
        done_cnt = 0;
        got_res  = 16'hdead;
        @(negedge clk);
        a0 = 16'hffff; b0 = 16'h0001; op0 = 3'b010; req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done0) begin
                done_cnt++;
                got_res = res;
                req0 = 1'b0;
            end
        end
        tests_run++; if (busy_cnt != 2) begin tests_failed++; $display("FAIL ovf_busy_cycles: got %0d expected 2", busy_cnt); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL ovf_done_count: got %0d expected 1", done_cnt); end
        tests_run++; if (got_res !== 16'h0000) begin tests_failed++; $display("FAIL ovf_res: got %h expected 0000", got_res); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_late_req1();
        test_reset_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 expected completion");
        $fatal(1);
    end

endmodule
